axis_count_checker: RTL and testbench
=====================================

AXIS_COUNT_CHECKER -- requirements
Module: axis_count_checker

Interface
REQ-001 Parameter DataWidth, default 32, SHALL set the width of the stream data and the frame limit.
REQ-002 counter_clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 count_up  input  DataWidth  SHALL carry the stream data beat.
REQ-005 count_valid  input  1  SHALL be the stream valid from the upstream source.
REQ-006 count_last  input  1  SHALL mark the final beat of a frame.
REQ-007 count_ready  output  1  SHALL be the registered sink ready.
REQ-008 count_up_to  input  DataWidth  SHALL be the expected final data value of each frame.
REQ-009 clear_err  input  1  SHALL clear the sticky error flags and return the block to IDLE.
REQ-010 data_err  output  1  SHALL be a sticky flag for data mismatch.
REQ-011 last_err  output  1  SHALL be a sticky flag for a missing or spurious last.
REQ-012 frame_cnt  output  16  SHALL count error-free completed frames and saturate at 16'hFFFF.
REQ-013 busy  output  1  SHALL be high while a frame is in progress (RUN).

Function
REQ-014 A beat SHALL be accepted only on a cycle where count_valid and count_ready are both 1; all other cycles are ignored.
REQ-015 The FSM SHALL have three states: IDLE, RUN and FAIL.
REQ-016 IDLE -> RUN SHALL occur on an accepted beat; that beat SHALL be checked against expected = 0.
REQ-017 count_up_to SHALL be latched into limit_q on the first beat of each frame; changes mid-frame SHALL have no effect until the next frame.
REQ-018 In RUN, each accepted beat SHALL be compared with expected; expected SHALL then increment by 1, modulo 2^DataWidth.
REQ-019 A beat with data == limit SHALL require count_last = 1; the FSM SHALL then go to IDLE, reset expected to 0 and increment frame_cnt (saturating).
REQ-020 A beat with data != expected SHALL set data_err and move the FSM to FAIL.
REQ-021 count_last = 1 on a beat with data != limit, or count_last = 0 on a beat with data == limit, SHALL set last_err and move the FSM to FAIL.
REQ-022 If limit = 0, every frame SHALL be exactly one beat with data 0 and count_last = 1.
REQ-023 In FAIL, count_ready SHALL stay 1 and beats SHALL be drained without any further checks; the FSM SHALL leave FAIL only on clear_err.
REQ-024 clear_err SHALL clear data_err and last_err, force IDLE and set expected to 0; frame_cnt SHALL be kept.
REQ-025 If clear_err coincides with an accepted erroneous beat, clear_err SHALL win and the beat SHALL be discarded.
REQ-026 Error flags and frame_cnt SHALL update on the clock edge that accepts the beat (1-cycle latency).
REQ-027 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-028 Reset SHALL force: state IDLE, expected 0, limit_q 0, count_ready 0, data_err 0, last_err 0, frame_cnt 0, busy 0.
REQ-029 count_ready SHALL rise on the first clock edge after reset deasserts.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without counting it or flagging an error.

Configuration
REQ-031 With macro CHECKER_BACKPRESSURE_EN defined, count_ready SHALL equal bit 0 of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset, advancing every cycle).
REQ-032 Without CHECKER_BACKPRESSURE_EN, count_ready SHALL be 1 in every cycle after reset.

Structure
REQ-033 Package axis_count_checker_pkg SHALL hold the state enum, LFSR_SEED and LFSR_TAPS constants and the frame-counter width (16).
REQ-034 The LFSR SHALL be a sub-module named lfsr8 (ports counter_clk, reset, lfsr_q[7:0]), instantiated only under CHECKER_BACKPRESSURE_EN.

Verification
REQ-035 count_up_to = 3, stream 0,1,2,3 with last on 3, repeated 4 times -> frame_cnt = 4, no errors, busy low after the final last.
REQ-036 count_up_to = 3, stream 0,1,5 -> data_err = 1 the cycle after beat 5, state FAIL, frame_cnt unchanged; then clear_err -> flags 0, next 0..3 frame counts.
REQ-037 count_up_to = 3, last asserted on beat 2 -> last_err = 1; separately, last missing on beat 3 -> last_err = 1.
REQ-038 count_up_to = 0, five single beats of data 0 with last -> frame_cnt = 5; count_up_to changed from 3 to 7 mid-frame -> frame still ends at 3.
REQ-039 Reset pulsed after beat 1 of a frame -> all outputs at reset values, next frame from 0 checks clean.
REQ-040 CHECKER_BACKPRESSURE_EN defined, valid held high -> first 8 ready values match the LFSR bit-0 sequence from seed A5, and no beat is lost or duplicated.

Source files
------------

// File: rtl/axis_count_checker_pkg.sv
// Shared types and constants for the AXI-stream count checker.
package axis_count_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED   = 8'hA5;
  // Feedback taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS   = 8'hB8;
  localparam int         FRAME_CNT_W = 16;

  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (&v) ? v : v + FRAME_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_count_checker_lfsr8.sv
// 8-bit Fibonacci LFSR used to generate pseudo-random sink backpressure.
module lfsr8
  import axis_count_checker_pkg::*;
(
  input  logic       counter_clk,
  input  logic       reset,
  output logic [7:0] lfsr_q
);

  always_ff @(posedge counter_clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

endmodule

// File: rtl/axis_count_checker.sv
// Checks that each stream frame counts 0..count_up_to with last on the final beat.
// Optional build macro CHECKER_BACKPRESSURE_EN drives count_ready from an LFSR.
module axis_count_checker
  import axis_count_checker_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                   counter_clk,
  input  logic                   reset,
  input  logic [DataWidth-1:0]   count_up,
  input  logic                   count_valid,
  input  logic                   count_last,
  output logic                   count_ready,
  input  logic [DataWidth-1:0]   count_up_to,
  input  logic                   clear_err,
  output logic                   data_err,
  output logic                   last_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  state_e               state_q, state_d;
  logic [DataWidth-1:0] expected_q, limit_q, lim;
  logic                 ready_q;
  logic                 accept, chk, d_bad, l_bad, at_lim;

`ifdef CHECKER_BACKPRESSURE_EN
  logic [7:0] lfsr_q;
  lfsr8 u_lfsr (.counter_clk(counter_clk), .reset(reset), .lfsr_q(lfsr_q));
  assign count_ready = ready_q & lfsr_q[0];
`else
  assign count_ready = ready_q;
`endif

  // The first beat of a frame is judged against the live limit, which is also latched
  assign lim    = (state_q == ST_IDLE) ? count_up_to : limit_q;
  assign accept = count_valid & count_ready;
  assign chk    = accept & (state_q != ST_FAIL) & ~clear_err;
  assign d_bad  = count_up != expected_q;
  assign at_lim = count_up == lim;
  assign l_bad  = count_last != at_lim;

  always_ff @(posedge counter_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_err) state_d = ST_IDLE;
    else if (chk) begin
      if (d_bad || l_bad) state_d = ST_FAIL;
      else if (at_lim)    state_d = ST_IDLE;
      else                state_d = ST_RUN;
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_ff @(posedge counter_clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      expected_q <= '0;
      limit_q    <= '0;
      data_err   <= 1'b0;
      last_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (clear_err) begin
        data_err   <= 1'b0;
        last_err   <= 1'b0;
        expected_q <= '0;
      end else if (chk) begin
        if (state_q == ST_IDLE) limit_q <= count_up_to;
        if (d_bad) data_err <= 1'b1;
        if (l_bad) last_err <= 1'b1;
        if (d_bad || l_bad || at_lim) expected_q <= '0;
        else                          expected_q <= expected_q + DataWidth'(1);
        if (!d_bad && !l_bad && at_lim) frame_cnt <= sat_inc(frame_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axis_count_checker.sv
// Self-checking bench: directed vector table, randomized run against a frame-level model.
module tb_axis_count_checker;

  logic        clk = 1'b0;
  logic        reset, count_valid, count_last, clear_err;
  logic [31:0] count_up, count_up_to;
  logic        count_ready, data_err, last_err, busy;
  logic [15:0] frame_cnt;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  axis_count_checker #(.DataWidth(32)) dut (
    .counter_clk(clk), .reset(reset), .count_up(count_up), .count_valid(count_valid),
    .count_last(count_last), .count_ready(count_ready), .count_up_to(count_up_to),
    .clear_err(clear_err), .data_err(data_err), .last_err(last_err),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  // Frame-level reference: position within current frame, failed flag, counters
  bit       m_started, m_fail, m_de, m_le;
  int       m_pos, m_fc;
  longint   m_lim;
  bit [7:0] m_lfsr;

  function automatic bit m_rdy();
`ifdef CHECKER_BACKPRESSURE_EN
    return m_started && m_lfsr[0];
`else
    return m_started;
`endif
  endfunction

  task automatic model_step(input bit r, c, v, input logic [31:0] d, input bit l,
                            input logic [31:0] u);
    bit derr, lerr;
    if (r) begin
      m_started = 0; m_fail = 0; m_de = 0; m_le = 0; m_pos = 0; m_fc = 0; m_lim = 0;
      m_lfsr = 8'hA5;
      return;
    end
    if (c) begin
      m_de = 0; m_le = 0; m_fail = 0; m_pos = 0;
    end else if (v && m_rdy() && !m_fail) begin
      if (m_pos == 0) m_lim = u;
      derr = (longint'(d) != m_pos);
      lerr = (l != (longint'(d) == m_lim));
      if (derr) m_de = 1;
      if (lerr) m_le = 1;
      if (derr || lerr) begin m_fail = 1; m_pos = 0; end
      else if (longint'(d) == m_lim) begin m_pos = 0; if (m_fc < 65535) m_fc++; end
      else m_pos++;
    end
    m_started = 1;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic step(input bit r, c, v, input logic [31:0] d, input bit l, input logic [31:0] u);
    @(negedge clk);
    reset = r; clear_err = c; count_valid = v; count_up = d; count_last = l; count_up_to = u;
    model_step(r, c, v, d, l, u);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rdy"},  32'(count_ready), 32'(m_rdy()));
    check({tag, ".de"},   32'(data_err),    32'(m_de));
    check({tag, ".le"},   32'(last_err),    32'(m_le));
    check({tag, ".fc"},   32'(frame_cnt),   32'(m_fc));
    check({tag, ".busy"}, 32'(busy),        32'(m_pos > 0 && !m_fail));
  endtask

  typedef struct {
    bit r, c, v; logic [31:0] d; bit l; logic [31:0] u;
    bit rdy, de, le, busy; int fc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, c, v, logic [31:0] d, bit l, logic [31:0] u,
                              bit rdy, de, le, int fc, bit bz);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.d = d; t.l = l; t.u = u;
    t.rdy = rdy; t.de = de; t.le = le; t.fc = fc; t.busy = bz;
    return t;
  endfunction

  function automatic void push_frame(int fc0);
    for (int b = 0; b < 4; b++)
      tbl.push_back(mk(0,0,1, b, b == 3, 3, 1,0,0, fc0 + (b == 3 ? 1 : 0), b != 3));
  endfunction

  initial begin
    reset = 1; clear_err = 0; count_valid = 0; count_up = 0; count_last = 0; count_up_to = 0;
    // reset and idle
    tbl.push_back(mk(1,0,0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 32'hdead,1,3, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0, 5,1,3, 1,0,0,0,0));
    // four good frames
    for (int f = 0; f < 4; f++) push_frame(f);
    // data error, drain, clear coinciding with bad beat, good frame
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,4,1));
    tbl.push_back(mk(0,0,1, 1,0,3, 1,0,0,4,1));
    tbl.push_back(mk(0,0,1, 5,0,3, 1,1,0,4,0));
    tbl.push_back(mk(0,0,1, 9,1,3, 1,1,0,4,0));
    tbl.push_back(mk(0,1,1, 7,1,3, 1,0,0,4,0));
    push_frame(4);
    // early last, then missing last
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 1,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 2,1,3, 1,0,1,5,0));
    tbl.push_back(mk(0,1,0, 0,0,3, 1,0,0,5,0));
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 1,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 2,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 3,0,3, 1,0,1,5,0));
    tbl.push_back(mk(0,1,0, 0,0,3, 1,0,0,5,0));
    // skipping to the limit with last: data error only
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,5,1));
    tbl.push_back(mk(0,0,1, 3,1,3, 1,1,0,5,0));
    tbl.push_back(mk(0,1,0, 0,0,3, 1,0,0,5,0));
    // limit 0: single-beat frames, then a missing last
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,1, 0,1,0, 1,0,0,6+i,0));
    tbl.push_back(mk(0,0,1, 0,0,0, 1,0,1,10,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,0,0,10,0));
    // limit changed mid-frame is ignored
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,10,1));
    tbl.push_back(mk(0,0,1, 1,0,7, 1,0,0,10,1));
    tbl.push_back(mk(0,0,1, 2,0,7, 1,0,0,10,1));
    tbl.push_back(mk(0,0,1, 3,1,7, 1,0,0,11,0));
    // both errors at once on a limit-0 first beat
    tbl.push_back(mk(0,0,1, 1,1,0, 1,1,1,11,0));
    tbl.push_back(mk(0,1,0, 0,0,0, 1,0,0,11,0));
    // reset mid-frame abandons it
    tbl.push_back(mk(0,0,1, 0,0,3, 1,0,0,11,1));
    tbl.push_back(mk(0,0,1, 1,0,3, 1,0,0,11,1));
    tbl.push_back(mk(1,0,1, 2,0,3, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,3, 1,0,0,0,0));
    push_frame(0);

`ifndef CHECKER_BACKPRESSURE_EN
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].u);
      check($sformatf("vec%0d.rdy", i),  32'(count_ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d.de", i),   32'(data_err),    32'(tbl[i].de));
      check($sformatf("vec%0d.le", i),   32'(last_err),    32'(tbl[i].le));
      check($sformatf("vec%0d.fc", i),   32'(frame_cnt),   32'(tbl[i].fc));
      check($sformatf("vec%0d.busy", i), 32'(busy),        32'(tbl[i].busy));
    end
`endif

    // randomized run; ready sequence checked every cycle (LFSR under backpressure)
    step(1,0,0, 0,0,0);
    check_model("rst");
    for (int i = 0; i < 1500; i++) begin
      bit r, c, v, l;
      logic [31:0] d, u;
      longint limv;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 5);
      limv = (m_pos == 0) ? longint'(u) : m_lim;
      d = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(0, 7)) : 32'(m_pos);
      l = (longint'(d) == limv);
      if ($urandom_range(0, 24) == 0) l = !l;
      step(r, c, v, d, l, u);
      check_model($sformatf("rnd%0d", i));
    end

`ifndef CHECKER_BACKPRESSURE_EN
    // frame counter saturation
    step(1,0,0, 0,0,0);
    step(0,0,0, 0,0,0);
    for (int i = 0; i < 65540; i++) step(0,0,1, 0,1,0);
    check("sat.fc", 32'(frame_cnt), 32'hFFFF);
    check("sat.de", 32'(data_err), 32'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
